// File: rtl/game_pkg.sv
// Shared game-domain definitions: scene codes, queue entry layout, time limits
// and the sequencer state encoding.
package game_pkg;

    localparam logic [1:0] S_TITLE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [2:0]  ENEMY_TYPE_NULL = 3'd0;
    localparam int          TS_MSB          = 14;
    localparam int          TS_LSB          = 3;
    localparam int          TYPE_MSB        = 2;
    localparam logic [11:0] TIME_MAX        = 12'd4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROM,
        ST_WAIT_TIME,
        ST_OFFER,
        ST_DONE
    } spawn_state_t;

    typedef struct packed {
        logic [11:0] ts;
        logic [2:0]  etype;
    } queue_entry_t;

    // Level code 3 does not exist in the ROM; it falls back to level 1.
    function automatic logic [1:0] level_fix(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd0 : sel;
    endfunction

endpackage

// File: rtl/enemy_spawn_sequencer_tick_divider.sv
// Divides frame ticks down to game-time units; game time saturates instead of
// wrapping so late-level timestamps never re-trigger.
module tick_divider
    import game_pkg::*;
#(
    parameter int TICK_DIV = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_frame_tick,
    output logic [11:0] o_game_time
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [11:0]      r_time;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_div  <= '0;
            r_time <= '0;
        end else if (i_enable && i_frame_tick) begin
            if (r_div == DIV_W'(TICK_DIV - 1)) begin
                r_div <= '0;
                if (r_time != TIME_MAX) begin
                    r_time <= r_time + 12'd1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_game_time = r_time;

endmodule

// File: rtl/enemy_spawn_sequencer.sv
// Walks the per-level enemy wave ROM and offers each entry as a spawn request
// once game time reaches its timestamp.
module enemy_spawn_sequencer
    import game_pkg::*;
#(
    parameter  int QUEUE_DEPTH = 64,
    parameter  int TICK_DIV    = 6,
    parameter  int ROM_LAT     = 1,
    localparam int IDX_W       = $clog2(QUEUE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_tick,
    input  logic             i_start,
    input  logic [1:0]       i_level_sel,
    input  logic             i_run,
    output logic [IDX_W+1:0] o_rom_addr,
    input  logic [14:0]      i_rom_data,
    output logic             o_spawn_valid,
    output logic [2:0]       o_spawn_type,
    input  logic             i_spawn_ready,
    output logic [11:0]      o_game_time,
    output logic             o_queue_done
);

    // state     | meaning
    // IDLE      | waiting for start
    // FETCH     | address of current entry is on the ROM bus
    // WAIT_ROM  | ROM latency; entry captured on the last cycle
    // WAIT_TIME | waiting for game time (and run) to reach the timestamp
    // OFFER     | spawn_valid held until the engine accepts
    // DONE      | sentinel or end of queue, held until start

    localparam int LAT_W = 2;

    spawn_state_t     r_state;
    logic [1:0]       r_level;
    logic [IDX_W-1:0] r_index;
    logic [LAT_W-1:0] r_lat_cnt;
    queue_entry_t     r_entry;
    logic [IDX_W+1:0] r_rom_addr;
    logic             r_spawn_valid;
    logic [2:0]       r_spawn_type;
    logic             r_queue_done;

    logic [11:0]      w_game_time;
    logic             w_tick_en;
    logic [IDX_W-1:0] w_next_index;

    assign w_tick_en    = i_run && (r_state != ST_IDLE);
    assign w_next_index = r_index + 1'b1;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (i_start),
        .i_enable     (w_tick_en),
        .i_frame_tick (i_frame_tick),
        .o_game_time  (w_game_time)
    );

    // The ROM address is loaded on entry to FETCH so the data window lines up
    // with exactly ROM_LAT cycles of WAIT_ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_level       <= '0;
            r_index       <= '0;
            r_lat_cnt     <= '0;
            r_entry       <= '0;
            r_rom_addr    <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_type  <= '0;
            r_queue_done  <= 1'b0;
        end else if (i_start) begin
            r_level       <= level_fix(i_level_sel);
            r_index       <= '0;
            r_rom_addr    <= {level_fix(i_level_sel), {IDX_W{1'b0}}};
            r_spawn_valid <= 1'b0;
            r_queue_done  <= 1'b0;
            r_state       <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_lat_cnt <= '0;
                    r_state   <= ST_WAIT_ROM;
                end
                ST_WAIT_ROM: begin
                    if (r_lat_cnt == LAT_W'(ROM_LAT - 1)) begin
                        r_entry.ts    <= i_rom_data[TS_MSB:TS_LSB];
                        r_entry.etype <= i_rom_data[TYPE_MSB:0];
                        if (i_rom_data[TYPE_MSB:0] == ENEMY_TYPE_NULL) begin
                            r_queue_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_TIME;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                ST_WAIT_TIME: begin
                    if (i_run && (w_game_time >= r_entry.ts)) begin
                        r_spawn_valid <= 1'b1;
                        r_spawn_type  <= r_entry.etype;
                        r_state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (i_spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        if (r_index == IDX_W'(QUEUE_DEPTH - 1)) begin
                            r_queue_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_index    <= w_next_index;
                            r_rom_addr <= {r_level, w_next_index};
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_spawn_valid <= 1'b0;
                end
                ST_IDLE: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr    = r_rom_addr;
    assign o_spawn_valid = r_spawn_valid;
    assign o_spawn_type  = r_spawn_type;
    assign o_game_time   = w_game_time;
    assign o_queue_done  = r_queue_done;

endmodule

// File: tb/tb_enemy_spawn_sequencer.sv
// Bench for enemy_spawn_sequencer: directed scenarios plus a randomized run,
// all checked every cycle against a schedule-based model of the queue.
module tb_enemy_spawn_sequencer;

    localparam int QUEUE_DEPTH = 64;
    localparam int TICK_DIV    = 6;
    localparam int ROM_LAT     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  level_sel = 2'd0;
    logic        run = 1'b0;
    logic [7:0]  rom_addr;
    logic [14:0] rom_data;
    logic        spawn_valid;
    logic [2:0]  spawn_type;
    logic        spawn_ready = 1'b0;
    logic [11:0] game_time;
    logic        queue_done;

    always #5 clk = ~clk;

    enemy_spawn_sequencer #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .TICK_DIV    (TICK_DIV),
        .ROM_LAT     (ROM_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_tick  (frame_tick),
        .i_start       (start),
        .i_level_sel   (level_sel),
        .i_run         (run),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_spawn_valid (spawn_valid),
        .o_spawn_type  (spawn_type),
        .i_spawn_ready (spawn_ready),
        .o_game_time   (game_time),
        .o_queue_done  (queue_done)
    );

    // ROM with ROM_LAT cycles of read latency
    logic [14:0] rom_mem [256];
    logic [14:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] ent(input int ts, input int ty);
        logic [11:0] t;
        logic [2:0]  y;
        t = 12'(ts);
        y = 3'(ty);
        return {t, y};
    endfunction

    // Reference model: tracks what the queue must be doing from the rules
    // (fetch result due ROM_LAT+1 edges after an address is issued, offer once
    // time and run allow, hand-off on accept) rather than any state encoding.
    int cyc = 0;
    bit m_act, m_fetch, m_wait, m_valid, m_done;
    int m_lvl, m_idx, m_time, m_div, m_cap_at, m_ts, m_type, m_addr;

    initial begin
        logic [14:0] e;
        int t_old;
        m_act = 0; m_fetch = 0; m_wait = 0; m_valid = 0; m_done = 0;
        m_lvl = 0; m_idx = 0; m_time = 0; m_div = 0; m_cap_at = 0;
        m_ts = 0; m_type = 0; m_addr = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_act = 0; m_fetch = 0; m_wait = 0; m_valid = 0; m_done = 0;
                m_lvl = 0; m_idx = 0; m_time = 0; m_div = 0; m_addr = 0;
            end else if (start) begin
                m_lvl    = (level_sel == 2'd3) ? 0 : int'(level_sel);
                m_idx    = 0;
                m_act    = 1; m_fetch = 1; m_wait = 0; m_valid = 0; m_done = 0;
                m_cap_at = cyc + ROM_LAT + 1;
                m_addr   = m_lvl * QUEUE_DEPTH;
                m_time   = 0; m_div = 0;
            end else begin
                t_old = m_time;
                if (m_act && run && frame_tick) begin
                    if (m_div == TICK_DIV - 1) begin
                        m_div = 0;
                        if (m_time < 4095) m_time++;
                    end else begin
                        m_div++;
                    end
                end
                if (m_fetch && cyc == m_cap_at) begin
                    e = rom_mem[8'(m_lvl * QUEUE_DEPTH + m_idx)];
                    m_fetch = 0;
                    if (e[2:0] == 3'd0) begin
                        m_done = 1;
                    end else begin
                        m_wait = 1;
                        m_ts   = int'(e[14:3]);
                        m_type = int'(e[2:0]);
                    end
                end else if (m_wait && run && t_old >= m_ts) begin
                    m_wait  = 0;
                    m_valid = 1;
                end else if (m_valid && spawn_ready) begin
                    m_valid = 0;
                    if (m_idx == QUEUE_DEPTH - 1) begin
                        m_done = 1;
                    end else begin
                        m_idx++;
                        m_fetch  = 1;
                        m_cap_at = cyc + ROM_LAT + 1;
                        m_addr   = m_lvl * QUEUE_DEPTH + m_idx;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("valid", 32'(spawn_valid), 32'(m_valid));
                if (m_valid) chk("type", 32'(spawn_type), m_type);
                chk("rom_addr", 32'(rom_addr), m_addr);
                chk("game_time", 32'(game_time), m_time);
                chk("queue_done", 32'(queue_done), 32'(m_done));
            end
        end
    end

    // Accepted spawns and frame ticks as seen on the ports
    int n_acc = 0;
    int tick_cnt = 0;
    int acc_type [$];
    int acc_tick [$];
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && spawn_valid && spawn_ready) begin
                n_acc++;
                acc_type.push_back(int'(spawn_type));
                acc_tick.push_back(tick_cnt);
            end
            if (frame_tick) tick_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_acc = 0; tick_cnt = 0;
        acc_type.delete(); acc_tick.delete();
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;
    endtask

    task automatic start_lvl(input int l);
        level_sel = 2'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tick_n(input int n, input int gap);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!spawn_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!spawn_valid) chk(name, 32'(spawn_valid), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses, ts;
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;

        // reset values
        do_reset();
        chk_en = 1'b1;
        chk("rst_valid", 32'(spawn_valid), 0);
        chk("rst_type", 32'(spawn_type), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_time", 32'(game_time), 0);
        chk("rst_done", 32'(queue_done), 0);

        // level 2 immediate spawn
        rom_mem[8'h40] = ent(0, 3);
        run = 1'b1; spawn_ready = 1'b1;
        start_lvl(1);
        chk("s1_addr", 32'(rom_addr), 32'h40);
        k = 1;
        while (!spawn_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("s1_latency", k, 3 + ROM_LAT);
        chk("s1_type", 32'(spawn_type), 3);
        pulses = 0;
        repeat (10) begin
            if (spawn_valid) pulses++;
            @(negedge clk);
        end
        chk("s1_pulses", pulses, 1);
        chk("s1_done", 32'(queue_done), 1);

        // timed spawns on level 1
        do_reset();
        rom_mem[0] = ent(2, 1); rom_mem[1] = ent(2, 2); rom_mem[2] = ent(5, 4);
        run = 1'b1; spawn_ready = 1'b1;
        start_lvl(0);
        tick_n(60, 8);
        chk("s2_time", 32'(game_time), 10);
        chk("s2_count", n_acc, 3);
        if (acc_type.size() == 3) begin
            chk("s2_type0", acc_type[0], 1);
            chk("s2_type1", acc_type[1], 2);
            chk("s2_type2", acc_type[2], 4);
            chk("s2_tick0", acc_tick[0], 12);
            chk("s2_tick1", acc_tick[1], 12);
            chk("s2_tick2", acc_tick[2], 30);
        end

        // back-pressure during an offer
        do_reset();
        rom_mem[0] = ent(0, 5); rom_mem[1] = ent(0, 6);
        run = 1'b1; spawn_ready = 1'b0;
        start_lvl(0);
        wait_valid("s3_offer", 20);
        repeat (20) @(negedge clk);
        chk("s3_hold_valid", 32'(spawn_valid), 1);
        chk("s3_hold_type", 32'(spawn_type), 5);
        chk("s3_hold_addr", 32'(rom_addr), 0);
        chk("s3_hold_acc", n_acc, 0);
        spawn_ready = 1'b1;
        @(negedge clk);
        spawn_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("s3_one_accept", n_acc, 1);
        wait_valid("s3_offer2", 20);
        chk("s3_type2", 32'(spawn_type), 6);
        chk("s3_addr2", 32'(rom_addr), 1);
        spawn_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("s3_done", 32'(queue_done), 1);
        chk("s3_total", n_acc, 2);

        // run=0 freezes time and blocks new offers
        do_reset();
        rom_mem[0] = ent(0, 2); rom_mem[1] = ent(1, 3);
        run = 1'b0; spawn_ready = 1'b1;
        start_lvl(0);
        tick_n(30, 4);
        chk("s4_frozen_time", 32'(game_time), 0);
        chk("s4_frozen_acc", n_acc, 0);
        run = 1'b1;
        tick_n(3, 4);
        chk("s4_run_acc", n_acc, 1);
        chk("s4_run_time", 32'(game_time), 0);
        run = 1'b0;
        tick_n(30, 4);
        chk("s4_pause_time", 32'(game_time), 0);
        run = 1'b1;
        tick_n(3, 4);
        chk("s4_resume_time", 32'(game_time), 1);
        repeat (8) @(negedge clk);
        chk("s4_resume_acc", n_acc, 2);

        // sentinel at level 3 index 2
        do_reset();
        rom_mem[8'h80] = ent(1, 7); rom_mem[8'h81] = ent(3, 5); rom_mem[8'h82] = ent(9, 0);
        run = 1'b1; spawn_ready = 1'b1;
        start_lvl(2);
        tick_n(20, 2);
        tick_n(100, 2);
        chk("s5_count", n_acc, 2);
        if (acc_type.size() == 2) begin
            chk("s5_type0", acc_type[0], 7);
            chk("s5_type1", acc_type[1], 5);
        end
        chk("s5_done", 32'(queue_done), 1);
        chk("s5_valid", 32'(spawn_valid), 0);
        chk("s5_time", 32'(game_time), 20);

        // restart during the offer at index 5, with a simultaneous accept
        do_reset();
        for (int i = 0; i < 8; i++) rom_mem[i] = ent(0, (i % 7) + 1);
        run = 1'b1; spawn_ready = 1'b0;
        start_lvl(0);
        for (int i = 0; i < 5; i++) begin
            wait_valid("s6_offer", 20);
            spawn_ready = 1'b1;
            @(negedge clk);
            spawn_ready = 1'b0;
        end
        wait_valid("s6_offer5", 20);
        chk("s6_addr5", 32'(rom_addr), 5);
        chk("s6_type5", 32'(spawn_type), 6);
        level_sel = 2'd3; start = 1'b1; spawn_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; spawn_ready = 1'b0;
        chk("s6_valid_drop", 32'(spawn_valid), 0);
        chk("s6_time", 32'(game_time), 0);
        chk("s6_done", 32'(queue_done), 0);
        chk("s6_addr", 32'(rom_addr), 0);
        chk("s6_acc", n_acc, 6);
        wait_valid("s6_restart", 20);
        chk("s6_restart_type", 32'(spawn_type), 1);

        // reset while offering
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s7_valid", 32'(spawn_valid), 0);
        chk("s7_acc", n_acc, 6);
        repeat (5) @(negedge clk);
        chk("s7_idle_valid", 32'(spawn_valid), 0);

        // game time saturation
        do_reset();
        rom_mem[0] = ent(4095, 1);
        run = 1'b1; spawn_ready = 1'b1; frame_tick = 1'b1;
        start_lvl(0);
        repeat (24600) @(negedge clk);
        frame_tick = 1'b0;
        chk("s8_time_sat", 32'(game_time), 4095);
        chk("s8_acc", n_acc, 1);
        chk("s8_done", 32'(queue_done), 1);

        // randomized traffic over all three levels
        do_reset();
        for (int l = 0; l < 3; l++) begin
            ts = 0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                ts += $urandom_range(0, 2);
                rom_mem[8'(l * QUEUE_DEPTH + i)] = ent(ts, $urandom_range(1, 7));
            end
        end
        rom_mem[8'(QUEUE_DEPTH + $urandom_range(20, 50))] = ent(0, 0);
        rom_mem[8'(2 * QUEUE_DEPTH + $urandom_range(5, 30))] = ent(0, 0);
        start_lvl(0);
        repeat (15000) begin
            run         = ($urandom_range(0, 9) != 0);
            spawn_ready = ($urandom_range(0, 9) < 7);
            frame_tick  = ($urandom_range(0, 3) == 0);
            start       = ($urandom_range(0, 1999) == 0);
            level_sel   = 2'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 4999) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
